// File: rtl/sipo_deserializer_pkg.sv
// ----------------------------------------------------------------------------
// sipo_deserializer_pkg
//   Shared definitions for the serial-in/parallel-out deserializer slice.
//   Contents:
//     state_e  - frame FSM encoding (ST_COLLECT = 1'b0, ST_PARITY = 1'b1)
//     cnt_w()  - bit-counter width helper, $clog2(n) clamped to at least 1
//   Optional feature macro used by the importing files: SIPO_PARITY_EN
// ----------------------------------------------------------------------------
package sipo_deserializer_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PARITY  = 1'b1
    } state_e;

    // Width needed to count 0..n-1. A count of one still needs a 1-bit
    // register so that the port never collapses to zero width.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sipo_deserializer_mod_n_counter.sv
// ----------------------------------------------------------------------------
// mod_n_counter
//   Modulo-N up counter used as the deserializer's bit counter.
//   Counts 0..N-1 on enabled cycles and wraps back to 0.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   synchronous, active-high reset (count returns to 0)
//     en    in   advance the count this cycle
//     cnt   out  current count, cnt_w(N) bits
//     wrap  out  combinational: en is high while cnt is at N-1
// ----------------------------------------------------------------------------
module mod_n_counter
    import sipo_deserializer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [cnt_w(N)-1:0] cnt,
    output logic                wrap
);

    localparam int           W    = cnt_w(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = en && (cnt == LAST);

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// ----------------------------------------------------------------------------
// sipo_deserializer
//   Receive end of the shift-register datapath. Takes one bit per sin_valid
//   strobe, assembles DATA_W-bit words and hands each word to a one-entry
//   output register with a valid/ready handshake. Shifting never stalls: a
//   word completing while the held word is still unaccepted is dropped and
//   flagged with a one-cycle overrun pulse.
//
//   Optional feature macro: SIPO_PARITY_EN
//     defined   - each frame is DATA_W data bits plus one even-parity bit;
//                 parity_err qualifies pout and a bad word is still delivered
//     undefined - the last data bit completes the word; no parity_err port
//
//   Parameters:
//     DATA_W     word width in bits (>= 2)
//     MSB_FIRST  1: first received bit lands in pout[DATA_W-1]; 0: in pout[0]
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   synchronous, active-high reset, highest priority
//     sin         in   serial data bit
//     sin_valid   in   sin is sampled on edges where this is 1
//     out_ready   in   consumer accepts pout while pout_valid is 1
//     pout        out  assembled word, stable while held and not popped
//     pout_valid  out  pout holds an unconsumed word
//     busy        out  a partial frame is in progress
//     overrun     out  one-cycle pulse: a completed word was dropped
//     parity_err  out  (SIPO_PARITY_EN only) parity of the word in pout failed
// ----------------------------------------------------------------------------
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] pout,
    output logic              pout_valid,
    output logic              busy,
`ifdef SIPO_PARITY_EN
    output logic              overrun,
    output logic              parity_err
`else
    output logic              overrun
`endif
);

    localparam int CNT_W = cnt_w(DATA_W);

    state_e             state;
    state_e             state_next;
    logic [DATA_W-1:0]  sr;
    logic [DATA_W-1:0]  sr_next;
    logic [DATA_W-1:0]  word;
    logic [CNT_W-1:0]   cnt;
    logic               bit_en;
    logic               wrap;
    logic               complete;
    logic               pop;
`ifdef SIPO_PARITY_EN
    logic               perr_calc;
`endif

    // Data bits are only taken while collecting; the parity bit is not
    // shifted into the word.
    assign bit_en = sin_valid && (state == ST_COLLECT);
    assign pop    = pout_valid && out_ready;

    // ------------------------------------------------------------------
    // Bit counter
    // ------------------------------------------------------------------
    mod_n_counter #(
        .N (DATA_W)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (bit_en),
        .cnt  (cnt),
        .wrap (wrap)
    );

    // ------------------------------------------------------------------
    // Shift register
    // ------------------------------------------------------------------
    always_comb begin
        if (MSB_FIRST) begin
            sr_next = {sr[DATA_W-2:0], sin};
        end else begin
            sr_next = {sin, sr[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (bit_en) begin
            sr <= sr_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the block leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            ST_COLLECT: begin
`ifdef SIPO_PARITY_EN
                if (wrap) state_next = ST_PARITY;
`endif
            end
            ST_PARITY: begin
                if (sin_valid) state_next = ST_COLLECT;
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM: outputs
    // ------------------------------------------------------------------
    // The completion edge either samples the last data bit (word taken from
    // the shift-register input so it is available on that same edge) or,
    // with parity, samples the parity bit after the word is already in sr.
    always_comb begin
        busy     = (cnt != '0) || (state == ST_PARITY);
`ifdef SIPO_PARITY_EN
        complete  = sin_valid && (state == ST_PARITY);
        word      = sr;
        perr_calc = (^sr) ^ sin;
`else
        complete  = wrap;
        word      = sr_next;
`endif
    end

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    // A completing word is accepted when the slot is empty or is being
    // popped on this very edge, giving back-to-back delivery without a
    // bubble. Otherwise the new word is dropped and the held one kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            pout       <= '0;
            pout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!pout_valid || out_ready) begin
                    pout       <= word;
                    pout_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                    parity_err <= perr_calc;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pop) begin
                pout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// ----------------------------------------------------------------------------
// tb_sipo_deserializer
//   Drives an MSB-first and an LSB-first instance with the same bit stream.
//   A frame-level reference model collects sampled bits into a list, builds
//   the expected words from bit positions when a frame completes, tracks the
//   occupancy of the single output slot and pushes expected words into
//   scoreboard queues. A monitor on the falling edge pops and compares each
//   newly presented word, checks hold stability and busy, and counts
//   overrun pulses.
// ----------------------------------------------------------------------------
module tb_sipo_deserializer;

    localparam int DW = 8;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = DW + 1;
`else
    localparam int FRAME = DW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sin;
    logic          sin_valid;
    logic          out_ready;
    logic [DW-1:0] pout_m, pout_l;
    logic          pout_valid_m, pout_valid_l;
    logic          busy_m, busy_l;
    logic          overrun_m, overrun_l;
`ifdef SIPO_PARITY_EN
    logic          parity_err_m, parity_err_l;
`endif

    sipo_deserializer #(.DATA_W(DW), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .out_ready  (out_ready),
        .pout       (pout_m),
        .pout_valid (pout_valid_m),
        .busy       (busy_m),
`ifdef SIPO_PARITY_EN
        .overrun    (overrun_m),
        .parity_err (parity_err_m)
`else
        .overrun    (overrun_m)
`endif
    );

    sipo_deserializer #(.DATA_W(DW), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .out_ready  (out_ready),
        .pout       (pout_l),
        .pout_valid (pout_valid_l),
        .busy       (busy_l),
`ifdef SIPO_PARITY_EN
        .overrun    (overrun_l),
        .parity_err (parity_err_l)
`else
        .overrun    (overrun_l)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: frame-level, evaluated on each sampling edge
    // ------------------------------------------------------------------
    logic          bits[$];
    logic [DW:0]   exp_m[$];     // {parity_err, word}
    logic [DW:0]   exp_l[$];
    bit            slot_full = 0;
    int            ovr_exp   = 0;

    always @(posedge clk) begin
        logic [DW-1:0] wm, wl;
        logic          perr;
        bit            done;
        if (rst) begin
            bits.delete();
            exp_m.delete();
            exp_l.delete();
            slot_full = 0;
        end else begin
            done = 0;
            wm   = '0;
            wl   = '0;
            perr = 1'b0;
            if (sin_valid) begin
                bits.push_back(sin);
                if (bits.size() == FRAME) begin
                    done = 1;
                    for (int i = 0; i < DW; i++) begin
                        wm[DW-1-i] = bits[i];
                        wl[i]      = bits[i];
                    end
`ifdef SIPO_PARITY_EN
                    // Even parity over data plus parity bit must be zero.
                    for (int i = 0; i < FRAME; i++) perr ^= bits[i];
`endif
                    bits.delete();
                end
            end
            if (done) begin
                if (!slot_full || out_ready) begin
                    exp_m.push_back({perr, wm});
                    exp_l.push_back({perr, wl});
                    slot_full = 1;
                end else begin
                    ovr_exp++;
                end
            end else if (slot_full && out_ready) begin
                slot_full = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: falling-edge sampling, scoreboard pop on each new word
    // ------------------------------------------------------------------
    bit            prev_v = 0;
    bit            prev_r = 0;
    logic [DW-1:0] prev_pm, prev_pl;
    int            ovr_m = 0;
    int            ovr_l = 0;

    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst === 1'b1) begin
            prev_v = 0;
        end else begin
            check("busy_m", busy_m, bits.size() != 0);
            check("busy_l", busy_l, bits.size() != 0);
            check("valid_l_vs_model", pout_valid_l, slot_full);
            if (pout_valid_m) begin
                if (!prev_v || prev_r) begin
                    if (exp_m.size() == 0 || exp_l.size() == 0) begin
                        check("sb_has_entry", exp_m.size(), 1);
                    end else begin
                        e = exp_m.pop_front();
                        check("word_m", pout_m, e[DW-1:0]);
`ifdef SIPO_PARITY_EN
                        check("perr_m", parity_err_m, e[DW]);
`endif
                        e = exp_l.pop_front();
                        check("word_l", pout_l, e[DW-1:0]);
`ifdef SIPO_PARITY_EN
                        check("perr_l", parity_err_l, e[DW]);
`endif
                    end
                end else begin
                    check("hold_m", pout_m, prev_pm);
                    check("hold_l", pout_l, prev_pl);
                end
            end
            if (overrun_m) ovr_m++;
            if (overrun_l) ovr_l++;
            prev_v  = pout_valid_m;
            prev_r  = out_ready;
            prev_pm = pout_m;
            prev_pl = pout_l;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int maxgap, input bit rnd_ready);
        int gap;
        gap = $urandom_range(maxgap, 0);
        repeat (gap) begin
            sin_valid = 1'b0;
            sin       = 1'($urandom);
            if (rnd_ready) out_ready = 1'($urandom);
            step();
        end
        sin       = b;
        sin_valid = 1'b1;
        if (rnd_ready) out_ready = 1'($urandom);
        step();
        sin_valid = 1'b0;
    endtask

    // Bits leave MSB first, matching the upstream serializer.
    task automatic send_word(input logic [DW-1:0] w, input int maxgap,
                             input bit rnd_ready, input bit bad_par);
        for (int i = 0; i < DW; i++) send_bit(w[DW-1-i], maxgap, rnd_ready);
`ifdef SIPO_PARITY_EN
        send_bit((^w) ^ bad_par, maxgap, rnd_ready);
`else
        if (bad_par) sin = 1'b0;
`endif
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [DW-1:0] w;
        rst       = 1'b1;
        sin       = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b0;

        // Reset amid random input activity.
        repeat (3) begin
            sin       = 1'($urandom);
            sin_valid = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        check("rst_pout_m",    pout_m, 0);
        check("rst_pout_l",    pout_l, 0);
        check("rst_valid_m",   pout_valid_m, 0);
        check("rst_busy_m",    busy_m, 0);
        check("rst_overrun_m", overrun_m, 0);
`ifdef SIPO_PARITY_EN
        check("rst_perr_m",    parity_err_m, 0);
`endif
        rst       = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b1;

        // Stream 1,1,0,0,0,1,0,0 on consecutive strobes.
        send_word(8'hC4, 0, 0, 0);
        check("c4_valid",   pout_valid_m, 1);
        check("c4_msb",     pout_m, 8'hC4);
        check("c4_lsb",     pout_l, 8'h23);
        step();
        check("c4_valid_one_cycle", pout_valid_m, 0);

        // Same stream with random gaps.
        send_word(8'hC4, 3, 0, 0);
        check("gap_msb", pout_m, 8'hC4);
        check("gap_lsb", pout_l, 8'h23);
        step();

        // Overrun: held word kept, second word dropped.
        out_ready = 1'b0;
        send_word(8'hC4, 0, 0, 0);
        send_word(8'h5A, 0, 0, 0);
        check("ovr_pulse",   overrun_m, 1);
        check("ovr_hold_m",  pout_m, 8'hC4);
        step();
        check("ovr_one_cycle", overrun_m, 0);
        check("ovr_still_c4",  pout_m, 8'hC4);
        out_ready = 1'b1;
        step();
        check("pop_drops_valid", pout_valid_m, 0);

        // Completion and pop on the same edge.
        out_ready = 1'b0;
        send_word(8'h5A, 0, 0, 0);
        w = 8'h96;
        for (int i = 0; i < DW - 1; i++) send_bit(w[DW-1-i], 0, 0);
`ifdef SIPO_PARITY_EN
        send_bit(w[0], 0, 0);
        out_ready = 1'b1;
        send_bit(^w, 0, 0);
`else
        out_ready = 1'b1;
        send_bit(w[0], 0, 0);
`endif
        check("b2b_no_overrun", overrun_m, 0);
        check("b2b_valid",      pout_valid_m, 1);
        check("b2b_word",       pout_m, 8'h96);
        step();

        // Reset mid-word discards the partial word.
        send_bit(1'b1, 0, 0);
        send_bit(1'b0, 0, 0);
        send_bit(1'b1, 0, 0);
        send_bit(1'b1, 0, 0);
        send_bit(1'b0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        send_word(8'h81, 0, 0, 0);
        check("abort_msb", pout_m, 8'h81);
        check("abort_lsb", pout_l, 8'h81);
        step();

`ifdef SIPO_PARITY_EN
        send_word(8'hC4, 0, 0, 0);
        check("par_good", parity_err_m, 0);
        step();
        send_word(8'hC4, 0, 0, 1);
        check("par_bad",      parity_err_m, 1);
        check("par_bad_word", pout_m, 8'hC4);
        step();
`endif

        // Randomised traffic with random backpressure.
        for (int n = 0; n < 40; n++) send_word(8'($urandom), 3, 1, 1'($urandom));

        out_ready = 1'b1;
        repeat (4) step();
        check("sb_drained_m", exp_m.size(), 0);
        check("sb_drained_l", exp_l.size(), 0);
        check("overrun_count_m", ovr_m, ovr_exp);
        check("overrun_count_l", ovr_l, ovr_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
